// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
// Default geometry, address type and clear-sweep state encoding.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  typedef enum logic [0:0] {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/regfile_if.sv
// Register file access bundle: decode reads, writeback and
// long-latency return writes, scoreboard issue marking, status.
interface regfile_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);

  localparam int AW = $clog2(NREGS);

  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_pending;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic                     sb_set;
  logic [AW-1:0]            sb_addr;
  logic                     init_busy;
  logic [XLEN-1:0]          led_out;

  modport master (
    output rd_addr,
    output wr_en,
    output wr_addr,
    output wr_data,
    output sb_set,
    output sb_addr,
    input  rd_data,
    input  rd_pending,
    input  init_busy,
    input  led_out
  );

  modport slave (
    input  rd_addr,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  sb_set,
    input  sb_addr,
    output rd_data,
    output rd_pending,
    output init_busy,
    output led_out
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write bits for long-latency results.
// A new issue (set) overrides a same-cycle return (clear).
module regfile_scoreboard #(
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             set_i,
  input  logic [AW-1:0]    set_addr_i,
  input  logic             clr_i,
  input  logic [AW-1:0]    clr_addr_i,
  output logic [NREGS-1:0] pend_o
);

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  always_comb begin
    pend_d = pend_q;
    if (en_i) begin
      if (clr_i) pend_d[clr_addr_i] = 1'b0;
      if (set_i) pend_d[set_addr_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write bypass, pending
// scoreboard and a reset-time sequential clear sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) (
  input logic      clk,
  input logic      reset,
  regfile_if.slave bus
);

  localparam int AW = $clog2(NREGS);
  localparam logic [0:0] ST_SWEEP = SWEEP;
  localparam logic [0:0] ST_RUN   = RUN;

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]  mem_q [NREGS];
  logic             busy;
  logic [NREGS-1:0] pend;

  logic [NRD-1:0][XLEN-1:0] rd_data_d;
  logic [NRD-1:0]           rd_pend_d;

  assign busy = (state_q == ST_SWEEP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (busy) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(NREGS - 1)) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Later ports overwrite earlier ones on an address clash.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busy) begin
        mem_q[cnt_q] <= '0;
      end else begin
        for (int j = 0; j < NWR; j++) begin
          if (bus.wr_en[j] && bus.wr_addr[j] != '0)
            mem_q[bus.wr_addr[j]] <= bus.wr_data[j];
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREGS(NREGS)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .en_i       (!busy),
    .set_i      (bus.sb_set),
    .set_addr_i (bus.sb_addr),
    .clr_i      (bus.wr_en[NWR-1]),
    .clr_addr_i (bus.wr_addr[NWR-1]),
    .pend_o     (pend)
  );

  always_comb begin
    rd_data_d = '0;
    rd_pend_d = '0;
    for (int i = 0; i < NRD; i++) begin
      if (!busy && bus.rd_addr[i] != '0) begin
        rd_data_d[i] = mem_q[bus.rd_addr[i]];
        for (int j = 0; j < NWR; j++) begin
          if (bus.wr_en[j] && bus.wr_addr[j] == bus.rd_addr[i])
            rd_data_d[i] = bus.wr_data[j];
        end
        rd_pend_d[i] = pend[bus.rd_addr[i]] &&
          !(bus.wr_en[NWR-1] &&
            bus.wr_addr[NWR-1] == bus.rd_addr[i]);
      end
    end
  end

  assign bus.rd_data    = rd_data_d;
  assign bus.rd_pending = rd_pend_d;
  assign bus.init_busy  = busy;
  assign bus.led_out    = busy ? '0 : mem_q[NREGS-1];

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the core datapath. It replaces the single-write, negedge-write register file with:
- N read ports and M posedge write ports, with same-cycle write-to-read bypass.
- A pending-write scoreboard for long-latency results returned by the GEMM accelerator and load path.
- A synchronous reset that sequentially clears the array.

It sits between decode (operand reads), writeback (port 0) and the accelerator/long-latency return path (port 1).

## Interface
Parameters:
- XLEN, 32, register width in bits
- NREGS, 32, number of architectural registers (power of two, ≥4)
- NRD, 2, number of read ports
- NWR, 2, number of write ports; port NWR-1 is the long-latency return port
- AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- rd_addr  in  NRD×AW  read addresses
- rd_data  out  NRD×XLEN  read data
- rd_pending  out  NRD  addressed register has an outstanding long-latency write
- wr_en  in  NWR  write enables
- wr_addr  in  NWR×AW  write addresses
- wr_data  in  NWR×XLEN  write data
- sb_set  in  1  mark sb_addr pending (long-latency op issued)
- sb_addr  in  AW  register to mark pending
- init_busy  out  1  clear sweep in progress; writes and sb_set are ignored
- led_out  out  XLEN  contents of register NREGS-1

## Operation
- **Register 0:**
  - Reads always return 0.
  - Writes to it are dropped.
  - It is never marked pending.
- **Reads:** combinational.
  - rd_data[i] = wr_data[j] if wr_en[j], wr_addr[j]==rd_addr[i] and the address is non-zero (bypass).
  - Otherwise rd_data[i] = the array value.
  - If several ports match, the highest-indexed j wins.
- **Writes:** posedge.
  - Multiple enabled ports to the same address: the highest index wins.
  - Distinct addresses are all written.
- **Scoreboard:** one pending bit per register.
  - sb_set sets bit[sb_addr].
  - A write on port NWR-1 clears bit[wr_addr[NWR-1]].
  - Simultaneous set and clear of the same register: set wins (a new issue overrides an old return).
  - Writes on other ports do not touch pending bits.
- **rd_pending[i]:** pending bit[rd_addr[i]] AND NOT (same-cycle port NWR-1 write to rd_addr[i]).
- **Clear-sweep FSM:**
  - States: SWEEP and RUN.
  - reset → SWEEP with counter=0 and all pending bits cleared.
  - Each SWEEP cycle with reset low writes 0 to reg[counter] and increments counter.
  - When counter==NREGS-1 is cleared, the FSM moves to RUN.
  - In SWEEP: rd_data=0, rd_pending=0, led_out=0.
- **Reset mid-sweep:** counter restarts at 0.
- **Reset during RUN:** re-enters SWEEP; in-flight accelerator returns are discarded.

## Timing
- **Reset values:**
  - init_busy=1.
  - rd_data=0, rd_pending=0, led_out=0.
  - All pending bits 0.
- init_busy stays high for exactly NREGS cycles after the first cycle with reset low, then drops.
- **Write latency:**
  - Visible on rd_data in the same cycle via bypass.
  - Visible from the array from the next cycle.
- Scoreboard set is visible on rd_pending the cycle after sb_set.
- Scoreboard clear takes effect combinationally in the write cycle and is stored at the next edge.
- led_out reflects the array only; no bypass, so it has 1-cycle latency.

## Structure
- **Package regfile_pkg:**
  - Default XLEN/NREGS constants.
  - Typedef reg_addr_t (logic [AW-1:0]).
  - Typedef sweep_state_e {SWEEP, RUN}.
- **Sub-module regfile_scoreboard:** holds the pending-bit vector plus the set/clear priority logic, parametrised on NREGS.
- The data array, bypass muxes and sweep FSM live in regfile_mp.

## Test plan
- Reset for 1 cycle, then release:
  - init_busy high for 32 cycles.
  - All reads 0 during the sweep.
  - After the sweep, every register reads 0.
  - A wr_en[0] attempted during the sweep is lost.
- Write 0xDEADBEEF to x5 on port 0 while rd_addr[0]=5:
  - rd_data[0]=0xDEADBEEF in the same cycle.
  - rd_data[0] still 0xDEADBEEF the next cycle with wr_en low.
- Both ports write x7 (port0=0x11, port1=0x22):
  - Bypass and stored value are both 0x22.
- Write 0x1234 to x0 on both ports:
  - rd_data=0.
  - rd_pending=0 even after sb_set with sb_addr=0.
- sb_set x9:
  - rd_pending=1 next cycle.
  - Port 1 writes x9=0x55 in the same cycle as sb_set x9: bit stays set.
  - Later port 1 write of x9 alone clears it; rd_pending drops in that cycle.
- Reset asserted at sweep count 10:
  - Sweep restarts at 0.
  - init_busy high for 32 cycles after the release.
  - led_out=0 until a write to x31.
